// File: rtl/frame_pkg.sv
// Shared frame definitions for the image tx/rx paths: sync bytes, header
// length, FSM state encoding and the header byte selector.
package frame_pkg;

  localparam logic [7:0]  FRAME_SYNC0 = 8'hA5;
  localparam logic [7:0]  FRAME_SYNC1 = 8'h5A;
  localparam int unsigned HDR_LEN     = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CKSUM   = 2'd3
  } frame_state_e;

  // Header layout: sync0, sync1, length high byte, length low byte.
  function automatic logic [7:0] hdr_byte(input logic [1:0]  idx,
                                          input logic [7:0]  s0,
                                          input logic [7:0]  s1,
                                          input logic [15:0] len);
    logic [7:0] b;
    case (idx)
      2'd0:    b = s0;
      2'd1:    b = s1;
      2'd2:    b = len[15:8];
      default: b = len[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tx_prefetch_fifo.sv
// Two-entry, 8-bit synchronous FIFO holding BRAM bytes prefetched ahead of
// the tx stream. Flush has priority over push and pop.
module tx_prefetch_fifo (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  input  logic       flush,
  output logic [7:0] head,
  output logic [1:0] count
);

  logic [7:0] mem_q [2];
  logic [7:0] mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/frame_tx_streamer.sv
// Streams one image frame (header, BRAM payload, XOR checksum) out of the
// image BRAM over a byte-wide valid/ready interface toward the SPI tx side.
module frame_tx_streamer
  import frame_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned FRAME_BYTES = 32768,
  parameter logic [7:0]  SYNC0       = FRAME_SYNC0,
  parameter logic [7:0]  SYNC1       = FRAME_SYNC1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  bram_rd_en,
  output logic [ADDR_WIDTH-1:0] bram_rd_addr,
  input  logic [7:0]            bram_rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  localparam int unsigned      CNT_W    = 17;
  localparam logic [CNT_W-1:0] N_BYTES  = CNT_W'(FRAME_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);
  localparam logic [15:0]      LEN16    = 16'(FRAME_BYTES);

  frame_state_e     state_q, state_d;
  logic [1:0]       hdr_idx_q, hdr_idx_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] pay_cnt_q, pay_cnt_d;
  logic [7:0]       csum_q, csum_d;
  logic             rd_pend_q, rd_pend_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic       fifo_push, fifo_pop, fifo_flush;
  logic [7:0] fifo_head;
  logic [1:0] fifo_count;

  logic       active, kill, xfer, rd_room, rd_issue;
  logic       valid_c;
  logic [7:0] byte_c;

  tx_prefetch_fifo u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (fifo_push),
    .push_data (bram_rd_data),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_comb begin
    valid_c = 1'b0;
    byte_c  = '0;
    case (state_q)
      ST_HDR: begin
        valid_c = 1'b1;
        byte_c  = hdr_byte(hdr_idx_q, SYNC0, SYNC1, LEN16);
      end
      ST_PAYLOAD: begin
        valid_c = (fifo_count != 2'd0);
        byte_c  = fifo_head;
      end
      ST_CKSUM: begin
        valid_c = 1'b1;
        byte_c  = csum_q;
      end
      default: ;
    endcase
  end

  assign active    = (state_q != ST_IDLE);
  assign kill      = active && abort;
  assign xfer      = valid_c && tx_ready;
  assign fifo_pop  = (state_q == ST_PAYLOAD) && xfer;
  // Returning data is dropped once the frame has left the active states.
  assign fifo_push = rd_pend_q && active;

  // Occupancy is counted after this cycle's pop so a pop and a refill read
  // can overlap; that keeps the payload gap-free at tx_ready=1.
  assign rd_room  = ({1'b0, fifo_count} + {2'b00, rd_pend_q}) < (3'd2 + {2'b00, fifo_pop});
  assign rd_issue = ((state_q == ST_HDR) || (state_q == ST_PAYLOAD)) && !abort &&
                    (rd_cnt_q < N_BYTES) && rd_room;

  always_comb begin
    state_d    = state_q;
    hdr_idx_d  = hdr_idx_q;
    rd_cnt_d   = rd_cnt_q + CNT_W'(rd_issue);
    pay_cnt_d  = pay_cnt_q;
    csum_d     = csum_q;
    rd_pend_d  = rd_issue;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d   = ST_HDR;
          hdr_idx_d = '0;
          csum_d    = '0;
          rd_cnt_d  = '0;
          pay_cnt_d = '0;
        end
      end
      ST_HDR: begin
        if (xfer) begin
          hdr_idx_d = hdr_idx_q + 2'd1;
          if (hdr_idx_q == 2'(HDR_LEN - 1)) state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (xfer) begin
          csum_d    = csum_q ^ fifo_head;
          pay_cnt_d = pay_cnt_q + 1'b1;
          if (pay_cnt_q == LAST_IDX) state_d = ST_CKSUM;
        end
      end
      ST_CKSUM: begin
        if (xfer) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (kill) begin
      state_d    = ST_IDLE;
      done_d     = 1'b0;
      aborted_d  = 1'b1;
      fifo_flush = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      hdr_idx_q <= '0;
      rd_cnt_q  <= '0;
      pay_cnt_q <= '0;
      csum_q    <= '0;
      rd_pend_q <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
      rd_cnt_q  <= rd_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      csum_q    <= csum_d;
      rd_pend_q <= rd_pend_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign tx_valid     = valid_c;
  assign tx_data      = valid_c ? byte_c : '0;
  assign bram_rd_en   = rd_issue;
  assign bram_rd_addr = ADDR_WIDTH'(rd_cnt_q);
  // busy rises combinationally in the cycle an accepted start is sampled.
  assign busy         = active || (start && !abort);
  assign done         = done_q;
  assign aborted      = aborted_q;

endmodule

// File: tb/tb_frame_tx_streamer.sv
// Bench for frame_tx_streamer: a 4-byte frame instance for the scenario
// tests and a default-size instance for the full 32768-byte frame.
module tb_frame_tx_streamer;

  localparam int FB_S = 4;
  localparam int FB_B = 32768;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        start_s = 1'b0, abort_s = 1'b0, tx_ready_s = 1'b1;
  logic        rd_en_s, tx_valid_s, busy_s, done_s, aborted_s;
  logic [14:0] addr_s;
  logic [7:0]  rd_data_s = '0, tx_data_s;

  logic        start_b = 1'b0, abort_b = 1'b0, tx_ready_b = 1'b1;
  logic        rd_en_b, tx_valid_b, busy_b, done_b, aborted_b;
  logic [14:0] addr_b;
  logic [7:0]  rd_data_b = '0, tx_data_b;

  frame_tx_streamer #(.ADDR_WIDTH(15), .FRAME_BYTES(FB_S), .SYNC0(8'hA5), .SYNC1(8'h5A)) dut_s (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_s), .abort(abort_s),
    .bram_rd_en(rd_en_s), .bram_rd_addr(addr_s), .bram_rd_data(rd_data_s),
    .tx_data(tx_data_s), .tx_valid(tx_valid_s), .tx_ready(tx_ready_s),
    .busy(busy_s), .done(done_s), .aborted(aborted_s));

  frame_tx_streamer dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_b), .abort(abort_b),
    .bram_rd_en(rd_en_b), .bram_rd_addr(addr_b), .bram_rd_data(rd_data_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .busy(busy_b), .done(done_b), .aborted(aborted_b));

  // BRAM models with one cycle of read latency.
  logic [7:0] mem_s [FB_S];
  always @(posedge sys_clk) if (rd_en_s) rd_data_s <= mem_s[addr_s[1:0]];
  always @(posedge sys_clk) if (rd_en_b) rd_data_b <= addr_b[7:0];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] got_s[$], exp_s[$], got_b[$];
  int n_done_s, n_abort_s, n_reads_s, n_badaddr_s, max_out_s;
  int n_done_b, n_reads_b, first_b, last_b;
  logic       ob_valid_s, ob_ready_s, ob_busy_s, ob_done_s, ob_abrt_s;
  logic [7:0] ob_data_s;

  task automatic tick();
    int pay;
    @(negedge sys_clk);
    cyc++;
    ob_valid_s = tx_valid_s;
    ob_ready_s = tx_ready_s;
    ob_data_s  = tx_data_s;
    ob_busy_s  = busy_s;
    ob_done_s  = done_s;
    ob_abrt_s  = aborted_s;
    if (tx_valid_s && tx_ready_s) got_s.push_back(tx_data_s);
    if (done_s) n_done_s++;
    if (aborted_s) n_abort_s++;
    if (rd_en_s) begin
      n_reads_s++;
      if (int'(addr_s) >= FB_S) n_badaddr_s++;
    end
    pay = got_s.size() - 4;
    if (pay < 0) pay = 0;
    if (pay > FB_S) pay = FB_S;
    if (n_reads_s - pay > max_out_s) max_out_s = n_reads_s - pay;
    if (tx_valid_b && tx_ready_b) begin
      if (got_b.size() == 0) first_b = cyc;
      last_b = cyc;
      got_b.push_back(tx_data_b);
    end
    if (done_b) n_done_b++;
    if (rd_en_b) n_reads_b++;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_small();
    got_s.delete();
    n_done_s = 0; n_abort_s = 0; n_reads_s = 0; n_badaddr_s = 0; max_out_s = 0;
  endtask

  // Reference frame: sync bytes, 16-bit length, payload, XOR of payload.
  task automatic model_small();
    logic [7:0] x;
    exp_s.delete();
    exp_s.push_back(8'hA5);
    exp_s.push_back(8'h5A);
    exp_s.push_back(8'((FB_S >> 8) & 255));
    exp_s.push_back(8'(FB_S & 255));
    x = 8'h00;
    for (int i = 0; i < FB_S; i++) begin
      exp_s.push_back(mem_s[i]);
      x = x ^ mem_s[i];
    end
    exp_s.push_back(x);
  endtask

  function automatic int diff_s();
    if (got_s.size() != exp_s.size()) return 1000 + got_s.size();
    for (int i = 0; i < exp_s.size(); i++) if (got_s[i] !== exp_s[i]) return i;
    return -1;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < FB_S; i++) mem_s[i] = 8'($urandom);
  endtask

  task automatic run_small(input bit rnd, output bit finished, output int holds);
    logic       prev_stall;
    logic [7:0] prev_data;
    clear_small();
    holds = 0;
    finished = 1'b0;
    tx_ready_s = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int c = 0; c < 300 && !finished; c++) begin
      prev_stall = ob_valid_s && !ob_ready_s;
      prev_data  = ob_data_s;
      tx_ready_s = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (prev_stall && !(ob_valid_s && ob_data_s == prev_data)) holds++;
      if (ob_done_s) finished = 1'b1;
    end
    tx_ready_s = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    n_checks++;
    if ({tx_data_s, tx_valid_s, rd_en_s, addr_s, busy_s, done_s, aborted_s} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_s: got data=%0h valid=%0b rd_en=%0b addr=%0h busy=%0b done=%0b aborted=%0b, expected all 0",
               tx_data_s, tx_valid_s, rd_en_s, addr_s, busy_s, done_s, aborted_s);
    end
    n_checks++;
    if ({tx_data_b, tx_valid_b, rd_en_b, addr_b, busy_b, done_b, aborted_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_b: got data=%0h valid=%0b busy=%0b, expected all 0", tx_data_b, tx_valid_b, busy_b);
    end
    sys_rst_n = 1'b1;
    clear_small();
    repeat (3) tick();
    n_checks++;
    if (ob_busy_s !== 1'b0 || ob_valid_s !== 1'b0 || n_done_s != 0 || n_abort_s != 0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%0b valid=%0b done=%0d aborted=%0d, expected 0 0 0 0",
               ob_busy_s, ob_valid_s, n_done_s, n_abort_s);
    end
  endtask

  task automatic test_nominal();
    for (int i = 0; i < FB_S; i++) mem_s[i] = 8'(i + 1);
    model_small();
    clear_small();
    tx_ready_s = 1'b1;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    n_checks++;
    if (ob_busy_s !== 1'b1 || ob_valid_s !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_start_cycle: got busy=%0b valid=%0b, expected busy=1 valid=0", ob_busy_s, ob_valid_s);
    end
    for (int k = 0; k < FB_S + 5; k++) begin
      tick();
      n_checks++;
      if (ob_valid_s !== 1'b1 || ob_data_s !== exp_s[k]) begin
        n_fail++;
        $display("FAIL nominal_byte%0d: got valid=%0b data=%0h, expected valid=1 data=%0h", k, ob_valid_s, ob_data_s, exp_s[k]);
      end
    end
    tick();
    n_checks++;
    if (ob_done_s !== 1'b1 || ob_busy_s !== 1'b0 || ob_valid_s !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_done: got done=%0b busy=%0b valid=%0b, expected 1 0 0", ob_done_s, ob_busy_s, ob_valid_s);
    end
    tick();
    n_checks++;
    if (ob_done_s !== 1'b0 || n_done_s != 1) begin
      n_fail++;
      $display("FAIL nominal_done_pulse: got done=%0b count=%0d, expected 0 and 1", ob_done_s, n_done_s);
    end
    n_checks++;
    if (n_reads_s != FB_S || n_badaddr_s != 0 || max_out_s > 2) begin
      n_fail++;
      $display("FAIL nominal_reads: got reads=%0d bad_addr=%0d max_outstanding=%0d, expected %0d 0 <=2",
               n_reads_s, n_badaddr_s, max_out_s, FB_S);
    end
  endtask

  task automatic test_backpressure();
    bit fin;
    int holds, d;
    for (int f = 0; f < 3; f++) begin
      fill_random();
      model_small();
      run_small(1'b1, fin, holds);
      n_checks++;
      if (!fin) begin
        n_fail++;
        $display("FAIL bp_timeout%0d: got no done, expected done within budget", f);
      end
      n_checks++;
      if (holds != 0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got %0d unstable stalled cycles, expected 0", f, holds);
      end
      d = diff_s();
      n_checks++;
      if (d != -1) begin
        n_fail++;
        $display("FAIL bp_frame%0d: got %0d bytes, expected %0d, first diff code %0d", f, got_s.size(), exp_s.size(), d);
      end
      n_checks++;
      if (n_done_s != 1 || max_out_s > 2 || n_badaddr_s != 0 || n_reads_s != FB_S) begin
        n_fail++;
        $display("FAIL bp_ctrl%0d: got done=%0d max_outstanding=%0d bad_addr=%0d reads=%0d, expected 1 <=2 0 %0d",
                 f, n_done_s, max_out_s, n_badaddr_s, n_reads_s, FB_S);
      end
    end
  endtask

  task automatic test_abort();
    bit fin;
    int holds, d, valid_after;
    for (int i = 0; i < FB_S; i++) mem_s[i] = 8'(i + 1);
    model_small();
    clear_small();
    tx_ready_s = 1'b1;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int c = 0; c < 50 && got_s.size() < 5; c++) tick();
    n_checks++;
    if (got_s.size() != 5) begin
      n_fail++;
      $display("FAIL abort_reach_payload: got %0d bytes, expected 5", got_s.size());
    end
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    n_checks++;
    if (got_s.size() != 6 || got_s[got_s.size()-1] !== mem_s[1]) begin
      n_fail++;
      $display("FAIL abort_same_cycle_xfer: got %0d bytes, expected 6 ending %0h", got_s.size(), mem_s[1]);
    end
    tick();
    n_checks++;
    if (ob_valid_s !== 1'b0 || ob_abrt_s !== 1'b1 || ob_busy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_effect: got valid=%0b aborted=%0b busy=%0b, expected 0 1 0", ob_valid_s, ob_abrt_s, ob_busy_s);
    end
    valid_after = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ob_valid_s) valid_after++;
    end
    n_checks++;
    if (n_abort_s != 1 || n_done_s != 0 || valid_after != 0) begin
      n_fail++;
      $display("FAIL abort_pulses: got aborted=%0d done=%0d valid_cycles=%0d, expected 1 0 0", n_abort_s, n_done_s, valid_after);
    end
    clear_small();
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    tick();
    tick();
    n_checks++;
    if (n_abort_s != 0 || ob_busy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got aborted=%0d busy=%0b, expected 0 0", n_abort_s, ob_busy_s);
    end
    start_s = 1'b1;
    abort_s = 1'b1;
    tick();
    start_s = 1'b0;
    abort_s = 1'b0;
    n_checks++;
    if (ob_busy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL start_abort_busy: got %0b, expected 0", ob_busy_s);
    end
    tick();
    n_checks++;
    if (ob_valid_s !== 1'b0 || ob_busy_s !== 1'b0 || n_abort_s != 0) begin
      n_fail++;
      $display("FAIL start_abort_idle: got valid=%0b busy=%0b aborted=%0d, expected 0 0 0", ob_valid_s, ob_busy_s, n_abort_s);
    end
    run_small(1'b0, fin, holds);
    d = diff_s();
    n_checks++;
    if (!fin || d != -1 || n_done_s != 1) begin
      n_fail++;
      $display("FAIL abort_restart: got done=%0d bytes=%0d diff=%0d, expected 1 %0d -1", n_done_s, got_s.size(), exp_s.size(), d);
    end
  endtask

  task automatic test_start_while_busy();
    int d;
    fill_random();
    model_small();
    clear_small();
    tx_ready_s = 1'b1;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    tick();
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int c = 0; c < 60 && n_done_s == 0; c++) tick();
    repeat (12) tick();
    d = diff_s();
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL busy_start_frame: got %0d bytes, expected %0d, diff code %0d", got_s.size(), exp_s.size(), d);
    end
    n_checks++;
    if (n_done_s != 1 || ob_busy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_done: got done=%0d busy=%0b, expected 1 0", n_done_s, ob_busy_s);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit fin;
    int holds, d;
    fill_random();
    model_small();
    clear_small();
    tx_ready_s = 1'b1;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int c = 0; c < 50 && got_s.size() < 6; c++) tick();
    #2;
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tx_data_s, tx_valid_s, rd_en_s, addr_s, busy_s, done_s, aborted_s} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got data=%0h valid=%0b rd_en=%0b addr=%0h busy=%0b done=%0b aborted=%0b, expected all 0",
               tx_data_s, tx_valid_s, rd_en_s, addr_s, busy_s, done_s, aborted_s);
    end
    tick();
    tick();
    sys_rst_n = 1'b1;
    clear_small();
    repeat (4) tick();
    n_checks++;
    if (n_done_s != 0 || n_abort_s != 0 || ob_busy_s !== 1'b0 || ob_valid_s !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got done=%0d aborted=%0d busy=%0b valid=%0b, expected 0 0 0 0",
               n_done_s, n_abort_s, ob_busy_s, ob_valid_s);
    end
    run_small(1'b0, fin, holds);
    d = diff_s();
    n_checks++;
    if (!fin || d != -1) begin
      n_fail++;
      $display("FAIL reset_restart: got %0d bytes diff=%0d, expected %0d bytes", got_s.size(), d, exp_s.size());
    end
  endtask

  task automatic test_default_size();
    int start_cyc, bad, first_bad;
    logic [7:0] x, e;
    got_b.delete();
    n_done_b = 0;
    n_reads_b = 0;
    tx_ready_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    start_cyc = cyc;
    for (int c = 0; c < FB_B + 100 && n_done_b == 0; c++) tick();
    n_checks++;
    if (n_done_b != 1 || got_b.size() != FB_B + 5) begin
      n_fail++;
      $display("FAIL big_length: got done=%0d bytes=%0d, expected 1 %0d", n_done_b, got_b.size(), FB_B + 5);
    end
    if (got_b.size() == FB_B + 5) begin
      n_checks++;
      if ({got_b[0], got_b[1], got_b[2], got_b[3]} !== 32'hA55A_8000) begin
        n_fail++;
        $display("FAIL big_header: got %0h %0h %0h %0h, expected a5 5a 80 00", got_b[0], got_b[1], got_b[2], got_b[3]);
      end
      bad = 0;
      first_bad = -1;
      x = 8'h00;
      for (int i = 0; i < FB_B; i++) begin
        e = 8'(i % 256);
        x = x ^ e;
        if (got_b[4 + i] !== e) begin
          bad++;
          if (first_bad < 0) first_bad = i;
        end
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL big_payload: got %0d wrong bytes (first at %0d), expected 0", bad, first_bad);
      end
      n_checks++;
      if (got_b[FB_B + 4] !== x) begin
        n_fail++;
        $display("FAIL big_checksum: got %0h, expected %0h", got_b[FB_B + 4], x);
      end
    end
    n_checks++;
    if (first_b != start_cyc + 1 || last_b - first_b != FB_B + 4 || n_reads_b != FB_B) begin
      n_fail++;
      $display("FAIL big_throughput: got first=%0d span=%0d reads=%0d, expected %0d %0d %0d",
               first_b, last_b - first_b, n_reads_b, start_cyc + 1, FB_B + 4, FB_B);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_abort();
    test_start_while_busy();
    test_reset_mid_frame();
    test_default_size();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_tx_streamer.md
Name: frame_tx_streamer

Overview:
Reads a completed image frame out of the image BRAM and streams it toward the ESP32 over a byte-wide valid/ready interface. The stream feeds the tx side of the SPI slave and is the return path for the receive path that fills the BRAM. The main state machine triggers it from its TRANSMITTING state. Each frame is sent as a header, the payload, then a checksum byte.

Parameters:
- ADDR_WIDTH, 15, BRAM address width.
- FRAME_BYTES, 32768, payload length in bytes; legal range 1..65535.
- SYNC0, 8'hA5, first header byte.
- SYNC1, 8'h5A, second header byte.

Ports:
- sys_clk  in  1  system clock (27 MHz).
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a frame; ignored while busy.
- abort  in  1  one-cycle pulse that terminates the frame in progress.
- bram_rd_en  out  1  BRAM read strobe.
- bram_rd_addr  out  ADDR_WIDTH  BRAM read address.
- bram_rd_data  in  8  BRAM data, valid exactly 1 cycle after bram_rd_en.
- tx_data  out  8  stream byte.
- tx_valid  out  1  tx_data holds a byte.
- tx_ready  in  1  sink accepts the byte.
- busy  out  1  high from the start cycle until done or aborted.
- done  out  1  one-cycle pulse after the checksum byte transfers.
- aborted  out  1  one-cycle pulse when an abort takes effect.

Behaviour:
- Reset (already decided): reset is sys_rst_n, asynchronous, active-low; clock is sys_clk. While reset is asserted every output is 0: tx_data=8'h00, tx_valid=0, bram_rd_en=0, bram_rd_addr=0, busy=0, done=0, aborted=0. The FSM is forced to IDLE and the prefetch FIFO is emptied. A reset mid-frame abandons the frame and emits no pulse.
- Transfer rule: a byte transfers on any cycle where tx_valid && tx_ready. While tx_valid=1 and tx_ready=0, tx_data must be held stable. tx_valid never drops until its byte has transferred, except on abort or reset.
- Frame format, 5+FRAME_BYTES bytes in order:
  - SYNC0
  - SYNC1
  - FRAME_BYTES[15:8]
  - FRAME_BYTES[7:0]
  - payload bytes at BRAM addresses 0..FRAME_BYTES-1
  - checksum byte = XOR of all payload bytes; header bytes are not included.
- FSM states: IDLE -> HDR -> PAYLOAD -> CKSUM -> IDLE.
  - IDLE: start=1 sets busy=1 and a 2-bit header index to 0, clears the checksum accumulator and read address, and moves to HDR. busy goes high the same cycle start is sampled.
  - HDR: presents header byte[idx]. tx_valid rises the cycle after start. Each transfer increments idx; after the transfer with idx=3 the FSM moves to PAYLOAD.
  - PAYLOAD: bytes come from the prefetch FIFO. Each transfer XORs the byte into the accumulator. After transfer number FRAME_BYTES the FSM moves to CKSUM.
  - CKSUM: presents the accumulator. On its transfer the FSM returns to IDLE, done pulses in the following cycle, and busy drops in that same cycle.
- Prefetch:
  - BRAM reads start in HDR so the payload follows the header with no gap.
  - bram_rd_en is issued only when FIFO occupancy plus reads in flight is less than 2.
  - The address increments by 1 per read. No read is issued beyond FRAME_BYTES-1, and the address never wraps within a frame.
  - Returned data is captured into a 2-deep FIFO on the cycle after bram_rd_en.
- Throughput: with tx_ready held at 1, all 5+FRAME_BYTES bytes transfer on consecutive cycles.
- Abort:
  - Takes effect in any non-IDLE state on the next cycle: tx_valid=0, FSM to IDLE, FIFO flushed, one aborted pulse, busy=0, and no done pulse.
  - In-flight BRAM data is discarded.
  - If abort and a transfer occur in the same cycle, the transfer counts but the frame still aborts.
  - abort in IDLE has no effect.
- Simultaneous events: start while busy is ignored. start and abort together in IDLE also start nothing.

Decomposition:
- Shared package (frame_pkg): SYNC0/SYNC1, the header length of 4, and the FSM state encodings, all used with the receive path.
- One sub-module: tx_prefetch_fifo, a 2-entry, 8-bit synchronous FIFO with push/pop/flush and count, reset to empty.

Test Plan:
- Nominal run: FRAME_BYTES=4, BRAM holds 01 02 03 04, tx_ready=1, start at cycle N -> bytes A5 5A 00 04 01 02 03 04 04 on cycles N+1..N+9, done at N+10, busy low at N+10.
- Backpressure: same frame with tx_ready toggling pseudo-randomly (50%) -> identical byte sequence, tx_data stable whenever valid&&!ready, and never more than 2 reads outstanding.
- Abort mid-payload: abort right after byte 01 transfers -> tx_valid=0 on the next cycle, one aborted pulse, no done, busy=0. A following start then produces the full 9-byte frame again.
- Start while busy: a second start pulse during HDR -> ignored; exactly one frame is sent and exactly one done pulse occurs.
- Reset mid-frame: assert sys_rst_n=0 during PAYLOAD -> all outputs 0 immediately and asynchronously. After release, idle with no pulses; the next start produces the full frame.
- Default size: FRAME_BYTES=32768, BRAM[i]=i[7:0], tx_ready=1 -> header A5 5A 80 00, then 32768 bytes on consecutive cycles, then checksum 00.
